// File: rtl/stream_demux_1t2_64_pkg.sv
// Shared defaults and channel-index constants for the 1-to-2 stream demux.
package stream_demux_1t2_64_pkg;
    localparam int DEF_WIDTH = 64;
    localparam int DEF_CNT_W = 16;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;
endpackage

// File: rtl/stream_demux_1t2_64_chan_fifo2.sv
// Two-entry per-channel FIFO: head register feeds the output, tail holds the second word.
module demux_chan_fifo2 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    logic [1:0]       r_occ;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_occ == 2'd2);
    assign o_empty = (r_occ == 2'd0);
    assign o_head  = r_head;

    // Push while full and pop while empty are dropped here so callers need not guard.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= i_push_data;
                    else               r_tail <= i_push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy holds; the new word lands behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/stream_demux_1t2_64.sv
// 1-to-2 registered stream demux: select steering, two channel FIFOs, per-channel counters.
module stream_demux_1t2_64
    import stream_demux_1t2_64_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic             w_full0, w_full1;
    logic             w_empty0, w_empty1;
    logic             w_push0, w_push1;
    logic [CNT_W-1:0] r_cnt0, r_cnt1;

    // Ready depends only on the selected channel's registered full bit.
    assign in_ready = (in_sel == CH1) ? !w_full1 : !w_full0;
    assign w_push0  = in_valid && in_ready && (in_sel == CH0);
    assign w_push1  = in_valid && in_ready && (in_sel == CH1);

    demux_chan_fifo2 #(.WIDTH(WIDTH)) u_chan0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push0),
        .i_push_data (in_data),
        .i_pop       (out0_ready),
        .o_full      (w_full0),
        .o_empty     (w_empty0),
        .o_head      (out0_data)
    );

    demux_chan_fifo2 #(.WIDTH(WIDTH)) u_chan1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push1),
        .i_push_data (in_data),
        .i_pop       (out1_ready),
        .o_full      (w_full1),
        .o_empty     (w_empty1),
        .o_head      (out1_data)
    );

    assign out0_valid = !w_empty0;
    assign out1_valid = !w_empty1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (cnt_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push0) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_push1) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
endmodule

// File: tb/tb_stream_demux_1t2_64.sv
// Self-checking bench for stream_demux_1t2_64: vector table, queue model, corner sequences.
module tb_stream_demux_1t2_64;
    logic        clk, rst_n;
    logic        in_valid, in_ready, in_sel;
    logic [63:0] in_data;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;
    logic [63:0] out0_data, out1_data;
    logic        cnt_clr;
    logic [15:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;

    stream_demux_1t2_64 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, sel;
        logic [63:0] d;
        logic        r0, r1, clr;
        logic        e_ir, e_o0v;
        logic [63:0] e_o0d;
        logic        e_o1v;
        logic [63:0] e_o1d;
        logic [15:0] e_c0, e_c1;
    } vec_t;

    vec_t tbl[11];

    // Reference model: one queue per channel plus plain counters.
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [15:0] m_c0, m_c1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic sel, input logic [63:0] d,
                         input logic r0, input logic r1, input logic clr, input logic do_chk);
        logic push, p0, p1;
        in_valid = v; in_sel = sel; in_data = d;
        out0_ready = r0; out1_ready = r1; cnt_clr = clr;
        #4;
        if (do_chk) begin
            chk("in_ready", in_ready, (sel ? q1.size() : q0.size()) < 2);
            chk("out0_valid", out0_valid, q0.size() != 0);
            if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
            chk("out1_valid", out1_valid, q1.size() != 0);
            if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
            chk("cnt0", cnt0, m_c0);
            chk("cnt1", cnt1, m_c1);
        end
        push = v && ((sel ? q1.size() : q0.size()) < 2);
        p0 = r0 && (q0.size() != 0);
        p1 = r1 && (q1.size() != 0);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (push && !sel) q0.push_back(d);
        if (push && sel)  q1.push_back(d);
        if (clr) begin
            m_c0 = 16'd0; m_c1 = 16'd0;
        end else if (push) begin
            if (sel) m_c1 = m_c1 + 16'd1;
            else     m_c0 = m_c0 + 16'd1;
        end
        #1;
    endtask

    initial begin
        int ir_low;
        // v sel d r0 r1 clr | ir o0v o0d o1v o1d c0 c1
        tbl[0]  = '{1'b1, 1'b0, 64'hA5A5_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 16'd0, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA5A5_0000_0000_0001, 1'b0, 64'h0, 16'd1, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 16'd1, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h11, 16'd1, 16'd1};
        tbl[4]  = '{1'b1, 1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h11, 16'd1, 16'd2};
        tbl[5]  = '{1'b1, 1'b0, 64'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h11, 16'd1, 16'd2};
        tbl[6]  = '{1'b1, 1'b1, 64'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h44, 1'b1, 64'h11, 16'd2, 16'd2};
        tbl[7]  = '{1'b1, 1'b1, 64'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h44, 1'b1, 64'h22, 16'd2, 16'd2};
        tbl[8]  = '{1'b0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h44, 1'b1, 64'h33, 16'd2, 16'd3};
        tbl[9]  = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h44, 1'b0, 64'h0, 16'd2, 16'd3};
        tbl[10] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 16'd2, 16'd3};

        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0; cnt_clr = 1'b0;
        #3;
        chk("rst out0_valid", out0_valid, 1'b0);
        chk("rst out1_valid", out1_valid, 1'b0);
        chk("rst in_ready sel0", in_ready, 1'b1);
        in_sel = 1'b1; #1;
        chk("rst in_ready sel1", in_ready, 1'b1);
        chk("rst cnt0", cnt0, 16'd0);
        chk("rst cnt1", cnt1, 16'd0);
        chk("rst out0_data", out0_data, 64'd0);
        #8 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].d;
            out0_ready = tbl[i].r0; out1_ready = tbl[i].r1; cnt_clr = tbl[i].clr;
            #4;
            chk($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d out0_valid", i), out0_valid, tbl[i].e_o0v);
            if (tbl[i].e_o0v) chk($sformatf("tbl%0d out0_data", i), out0_data, tbl[i].e_o0d);
            chk($sformatf("tbl%0d out1_valid", i), out1_valid, tbl[i].e_o1v);
            if (tbl[i].e_o1v) chk($sformatf("tbl%0d out1_data", i), out1_data, tbl[i].e_o1d);
            chk($sformatf("tbl%0d cnt0", i), cnt0, tbl[i].e_c0);
            chk($sformatf("tbl%0d cnt1", i), cnt1, tbl[i].e_c1);
            @(posedge clk); #1;
        end
        m_c0 = 16'd2; m_c1 = 16'd3;

        // Alternating select, both consumers ready.
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        ir_low = 0;
        for (int i = 0; i < 100; i++) begin
            in_sel = i[0]; #1;
            if (!in_ready) ir_low++;
            cycle(1'b1, i[0], 64'(i), 1'b1, 1'b1, 1'b0, 1'b1);
        end
        chk("alt in_ready lows", 64'(ir_low), 64'd0);
        chk("alt cnt0", cnt0, 16'd50);
        chk("alt cnt1", cnt1, 16'd50);
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Push and pop together with one entry held.
        cycle(1'b1, 1'b0, 64'h100, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 64'h101, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pp out0_valid", out0_valid, 1'b1);
        chk("pp out0_data", out0_data, 64'h101);
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pp drained", out0_valid, 1'b0);

        // Counter wrap and clear-wins.
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 65535; i++)
            cycle(1'b1, 1'b0, 64'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap pre cnt0", cnt0, 16'hFFFF);
        cycle(1'b1, 1'b0, 64'h55, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("wrap cnt0", cnt0, 16'h0000);
        cycle(1'b1, 1'b0, 64'h66, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("post wrap cnt0", cnt0, 16'h0001);
        cycle(1'b1, 1'b0, 64'h77, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr wins cnt0", cnt0, 16'h0000);
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Fill both channels, then reset asynchronously mid-cycle.
        cycle(1'b1, 1'b0, 64'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 64'hBB, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 64'hCC, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 64'hDD, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0; in_sel = 1'b1; #1;
        chk("full in_ready sel1", in_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst out0_valid", out0_valid, 1'b0);
        chk("arst out1_valid", out1_valid, 1'b0);
        chk("arst in_ready sel1", in_ready, 1'b1);
        in_sel = 1'b0; #1;
        chk("arst in_ready sel0", in_ready, 1'b1);
        chk("arst cnt0", cnt0, 16'd0);
        chk("arst cnt1", cnt1, 16'd0);
        q0.delete(); q1.delete(); m_c0 = 16'd0; m_c1 = 16'd0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
